// File: rtl/mxpfq_pkg.sv
// Shared types for the mxpfq instruction prefetch queue.
// Optional feature macro: MXPFQ_PC_TAG_EN (per-entry fetch address tag and dec_pc port).
package mxpfq_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no fetch outstanding
        REQ  = 2'd1,  // ce_n low, waiting for the BIU completion pulse
        CAPT = 2'd2,  // returned word on insr, written to the queue tail
        DROP = 2'd3   // returned word belongs to a flushed stream, discard it
    } state_e;

    // Default widths of the reference configuration.
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // Queue entry of the reference configuration. The top declares the same
    // layout sized by its own parameters.
    typedef struct packed {
`ifdef MXPFQ_PC_TAG_EN
        logic [DEF_ADDR_WIDTH-1:0] pc;
`endif
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/mxpfq_fifo.sv
// Circular buffer behind the prefetch queue: push at tail, pop at head,
// synchronous clear with priority over push and pop, occupancy count.
module mxpfq_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head word is forced to zero while empty so the output is defined
    // even though the storage array itself is never reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left without reset; its
        // contents are only observable through head_data, which is gated
        // by the (reset) count, so resetting it would only add muxes.
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mxpfq.sv
// Instruction prefetch queue: drives fetch address / chip-enable into the BIU,
// queues returned words, hands them to the decoder with valid/ready, and
// supports a flush/redirect that also discards an in-flight fetch.
// Optional feature macro: MXPFQ_PC_TAG_EN (per-entry fetch address, dec_pc port).
module mxpfq
    import mxpfq_pkg::*;
#(
    parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                  DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [ADDR_WIDTH-1:0] insp,
    output logic                  ce_n,
    input  logic [DATA_WIDTH-1:0] insr,
    input  logic                  valid,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_data
`ifdef MXPFQ_PC_TAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] dec_pc
`endif
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    // Entry layout sized by this instance's parameters.
    typedef struct packed {
`ifdef MXPFQ_PC_TAG_EN
        logic [ADDR_WIDTH-1:0] pc;
`endif
        logic [DATA_WIDTH-1:0] data;
    } q_entry_t;

    state_e                state;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] redirect;
    logic                  discard;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  room_idle;
    logic                  room_capt;
    q_entry_t              wr_entry;
    q_entry_t              head_entry;

    assign ce_n      = (state != REQ);
    assign dec_valid = ~empty & ~flush;
    assign pop       = dec_valid & dec_ready;
    assign push      = (state == CAPT) & ~flush;

    // A slot is reserved when entering REQ. From IDLE a flush empties the
    // queue, so it always leaves room. After a capture the queue holds
    // count+1-pop entries; count never exceeds DEPTH-1 while a fetch is out.
    assign room_idle = flush | ~full;
    assign room_capt = pop | (count < DEPTH_C - 1'b1);

    // Captured word; insp already advanced on the completion edge, so the
    // word's own address is one behind.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = insr;
`ifdef MXPFQ_PC_TAG_EN
        wr_entry.pc   = insp - 1'b1;
`endif
    end

    assign dec_data = head_entry.data;
`ifdef MXPFQ_PC_TAG_EN
    assign dec_pc   = head_entry.pc;
`endif

    mxpfq_fifo #(
        .WIDTH ($bits(q_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Fetch sequencer next-state decode.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_nxt;
        // a missing branch would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE: if (fetch_en && room_idle) state_nxt = REQ;
            REQ:  if (valid) state_nxt = (discard || flush) ? DROP : CAPT;
            CAPT: begin
                if (!flush && fetch_en && room_capt) state_nxt = REQ;
                else                                 state_nxt = IDLE;
            end
            DROP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, fetch address, and redirect bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            insp     <= RESET_PC;
            redirect <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (flush) insp <= flush_pc;
                REQ: begin
                    // The BIU may already be working on insp, so a flush
                    // only arms the discard and parks the new target.
                    if (valid) insp <= insp + 1'b1;
                    if (flush) begin
                        discard  <= 1'b1;
                        redirect <= flush_pc;
                    end
                end
                CAPT: if (flush) insp <= flush_pc;
                DROP: begin
                    discard <= 1'b0;
                    if (flush) begin
                        insp     <= flush_pc;
                        redirect <= flush_pc;
                    end else begin
                        insp     <= redirect;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mxpfq.sv
// Self-checking bench for mxpfq: BIU responder model, directed sequences,
// table-driven fill/wrap vectors and a randomized run against a stream model.
module tb_mxpfq;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic [AW-1:0] insp;
    logic          ce_n;
    logic [DW-1:0] insr;
    logic          valid;
    logic          dec_valid;
    logic          dec_ready;
    logic [DW-1:0] dec_data;
`ifdef MXPFQ_PC_TAG_EN
    logic [AW-1:0] dec_pc;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] imem [256];

    // BIU model state
    int            lat_min = 0;
    int            lat_max = 0;
    logic          busy;
    int            cnt;
    logic [AW-1:0] biu_addr;

    // fetch monitor
    int            nfetch = 0;
    logic [AW-1:0] last_fetch_addr = '0;
    logic          prev_ce_n = 1'b1;

    // stream model for the random phase
    logic          mon_en = 1'b0;
    logic [AW-1:0] exp_pc = '0;
    int            rnd_pops = 0;

    typedef struct {
        logic [AW-1:0] start;
        logic [AW-1:0] exp_end;
    } fill_vec_t;
    fill_vec_t fill_tab [5];

    always #5 clk = ~clk;

    mxpfq dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .insp      (insp),
        .ce_n      (ce_n),
        .insr      (insr),
        .valid     (valid),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_data  (dec_data)
`ifdef MXPFQ_PC_TAG_EN
        ,
        .dec_pc    (dec_pc)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush(input logic [AW-1:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        cyc(1);
        flush    = 1'b0;
    endtask

    // Wait (bounded) for a head word, check it, and accept it.
    task automatic pop_expect(input string nm, input logic [DW-1:0] d, input logic [AW-1:0] pc);
        int n = 0;
        string tag;
        tag = $sformatf("%s@%02h", nm, pc);
        while (!dec_valid && n < 60) begin
            cyc(1);
            n++;
        end
        check({tag, "_valid"}, 32'(dec_valid), 32'd1);
        check({tag, "_data"}, 32'(dec_data), 32'(d));
`ifdef MXPFQ_PC_TAG_EN
        check({tag, "_pc"}, 32'(dec_pc), 32'(pc));
`endif
        dec_ready = 1'b1;
        cyc(1);
        dec_ready = 1'b0;
    endtask

    // BIU responder: accepts a request while ce_n is low, pulses valid after a
    // random latency, and drives the word for that address the next cycle.
    initial begin
        valid    = 1'b0;
        insr     = '0;
        busy     = 1'b0;
        cnt      = 0;
        biu_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy  = 1'b0;
                valid = 1'b0;
                insr  = DW'($urandom);
            end else begin
                if (valid) begin
                    valid = 1'b0;
                    busy  = 1'b0;
                    insr  = imem[biu_addr];
                end else begin
                    insr  = DW'($urandom);
                end
                if (!busy && !ce_n) begin
                    busy     = 1'b1;
                    biu_addr = insp;
                    cnt      = int'($urandom_range(lat_max, lat_min));
                end
                if (busy && !valid) begin
                    check("biu_ce_hold", 32'(ce_n), 32'd0);
                    check("biu_insp_stable", 32'(insp), 32'(biu_addr));
                    if (cnt == 0) valid = 1'b1;
                    else          cnt--;
                end
            end
        end
    end

    // Fetch counter and decoder-stream model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && prev_ce_n && !ce_n) begin
            nfetch          <= nfetch + 1;
            last_fetch_addr <= insp;
        end
        prev_ce_n <= ce_n;
        if (mon_en && !rst) begin
            if (flush) begin
                check("rnd_flush_gate", 32'(dec_valid), 32'd0);
                exp_pc = flush_pc;
            end else if (dec_valid && dec_ready) begin
                check("rnd_data", 32'(dec_data), 32'(imem[exp_pc]));
`ifdef MXPFQ_PC_TAG_EN
                check("rnd_pc", 32'(dec_pc), 32'(exp_pc));
`endif
                exp_pc   = exp_pc + 1'b1;
                rnd_pops = rnd_pops + 1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            nf0;
        logic [AW-1:0] a;

        for (int i = 0; i < 256; i++) imem[i] = DW'($urandom);
        imem[0] = 8'h11;
        imem[1] = 8'h22;
        imem[2] = 8'h33;

        fill_tab[0] = '{start: 8'h00, exp_end: 8'h04};
        fill_tab[1] = '{start: 8'hFE, exp_end: 8'h02};
        fill_tab[2] = '{start: 8'hFF, exp_end: 8'h03};
        fill_tab[3] = '{start: 8'h40, exp_end: 8'h44};
        fill_tab[4] = '{start: 8'hFC, exp_end: 8'h00};

        // ---- reset values, first fetch timing, in-order delivery ----
        rst       = 1'b1;
        fetch_en  = 1'b1;
        flush     = 1'b0;
        flush_pc  = '0;
        dec_ready = 1'b0;
        #2;
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_insp", 32'(insp), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_data", 32'(dec_data), 32'd0);
`ifdef MXPFQ_PC_TAG_EN
        check("rst_dec_pc", 32'(dec_pc), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        check("c1_ce_n_low", 32'(ce_n), 32'd0);
        check("c1_insp", 32'(insp), 32'd0);
        cyc(1);
        check("capt_ce_n_high", 32'(ce_n), 32'd1);
        check("capt_no_valid_yet", 32'(dec_valid), 32'd0);
        cyc(1);
        check("push_dec_valid", 32'(dec_valid), 32'd1);
        check("push_dec_data", 32'(dec_data), 32'h11);
        check("b2b_ce_n_low", 32'(ce_n), 32'd0);
        pop_expect("seq0", 8'h11, 8'h00);
        pop_expect("seq1", 8'h22, 8'h01);
        pop_expect("seq2", 8'h33, 8'h02);

        // ---- table: fill to DEPTH, wrap, single refill, drain ----
        lat_min  = 1;
        lat_max  = 1;
        fetch_en = 1'b0;
        cyc(10);
        foreach (fill_tab[v]) begin
            string tn;
            tn = $sformatf("fill%0d", v);
            do_flush(fill_tab[v].start);
            nf0      = nfetch;
            fetch_en = 1'b1;
            cyc(40);
            check({tn, "_fetches"}, 32'(nfetch - nf0), 32'd4);
            check({tn, "_ce_n"}, 32'(ce_n), 32'd1);
            check({tn, "_insp"}, 32'(insp), 32'(fill_tab[v].exp_end));
            check({tn, "_head"}, 32'(dec_data), 32'(imem[fill_tab[v].start]));
            nf0 = nfetch;
            pop_expect({tn, "_pop"}, imem[fill_tab[v].start], fill_tab[v].start);
            cyc(20);
            a = fill_tab[v].start + 8'd4;
            check({tn, "_refetch_n"}, 32'(nfetch - nf0), 32'd1);
            check({tn, "_refetch_addr"}, 32'(last_fetch_addr), 32'(a));
            a = fill_tab[v].exp_end + 8'd1;
            check({tn, "_insp_after"}, 32'(insp), 32'(a));
            fetch_en = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                a = fill_tab[v].start + 8'(k);
                pop_expect({tn, "_drain"}, imem[a], a);
            end
            cyc(2);
            check({tn, "_empty"}, 32'(dec_valid), 32'd0);
        end

        // ---- flush while REQ with the BIU mid-transaction ----
        lat_min = 3;
        lat_max = 3;
        do_flush(8'h10);
        fetch_en = 1'b1;
        n = 0;
        while (ce_n && n < 20) begin
            cyc(1);
            n++;
        end
        check("fr_req_wait", 32'(ce_n), 32'd0);
        cyc(1);
        nf0 = nfetch;
        do_flush(8'h40);
        check("fr_ce_n_held", 32'(ce_n), 32'd0);
        check("fr_insp_held", 32'(insp), 32'h10);
        check("fr_queue_empty", 32'(dec_valid), 32'd0);
        n = 0;
        while (nfetch == nf0 && n < 30) begin
            cyc(1);
            n++;
        end
        check("fr_refetch_addr", 32'(last_fetch_addr), 32'h40);
        check("fr_still_empty", 32'(dec_valid), 32'd0);
        pop_expect("fr_first", imem[8'h40], 8'h40);

        // ---- flush and dec_ready in the same cycle with 2 entries ----
        lat_min  = 0;
        lat_max  = 0;
        fetch_en = 1'b0;
        cyc(10);
        do_flush(8'h20);
        fetch_en = 1'b1;
        cyc(30);
        fetch_en = 1'b0;
        cyc(5);
        pop_expect("fd_a", imem[8'h20], 8'h20);
        pop_expect("fd_b", imem[8'h21], 8'h21);
        check("fd_two_left", 32'(dec_valid), 32'd1);
        flush     = 1'b1;
        flush_pc  = 8'h60;
        dec_ready = 1'b1;
        #1;
        check("fd_gate", 32'(dec_valid), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        dec_ready = 1'b0;
        check("fd_count0", 32'(dec_valid), 32'd0);
        cyc(3);
        check("fd_still0", 32'(dec_valid), 32'd0);
        fetch_en = 1'b1;
        pop_expect("fd_redirect", imem[8'h60], 8'h60);

        // ---- asynchronous reset during REQ with words queued ----
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (!(dec_valid && !ce_n) && n < 40) begin
            cyc(1);
            n++;
        end
        check("ar_setup", 32'(dec_valid & ~ce_n), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_ce_n", 32'(ce_n), 32'd1);
        check("ar_insp", 32'(insp), 32'd0);
        check("ar_dec_valid", 32'(dec_valid), 32'd0);
        check("ar_dec_data", 32'(dec_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pop_expect("ar_restart", imem[8'h00], 8'h00);

        // ---- randomized run against the stream model ----
        lat_min = 0;
        lat_max = 3;
        cyc(1);
        mon_en   = 1'b1;
        flush    = 1'b1;
        flush_pc = AW'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            flush     = !flush && ($urandom_range(19, 0) == 0);
            flush_pc  = AW'($urandom);
            fetch_en  = ($urandom_range(7, 0) != 0);
            dec_ready = 1'($urandom_range(1, 0));
        end
        cyc(1);
        flush     = 1'b0;
        dec_ready = 1'b0;
        mon_en    = 1'b0;
        check("rnd_progress", 32'(rnd_pops > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mxpfq.md
# mxpfq

Instruction prefetch queue sitting directly upstream of the MX instruction bus interface unit. It drives the fetch address and chip-enable into the BIU, captures each returned instruction word into a DEPTH-entry circular queue, and presents words to the decoder through a valid/ready handshake. A flush/redirect input empties the queue and restarts fetching at a new address, discarding any fetch already in flight.

## Interface
- ADDR_WIDTH, 8, fetch address width
- DATA_WIDTH, 8, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  permit new fetches; in-flight fetch always completes
- flush  in  1  single-cycle redirect strobe
- flush_pc  in  ADDR_WIDTH  redirect target, sampled when flush=1
- insp  out  ADDR_WIDTH  fetch address to BIU
- ce_n  out  1  fetch request to BIU, active-low
- insr  in  DATA_WIDTH  BIU read data; valid the cycle after valid pulses
- valid  in  1  BIU completion pulse
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decoder accepts head
- dec_data  out  DATA_WIDTH  head instruction word
- dec_pc  out  ADDR_WIDTH  head word address (MXPFQ_PC_TAG_EN only)

## Operation
- States: IDLE, REQ, CAPT, DROP.
- IDLE: ce_n=1. If fetch_en and count<DEPTH → REQ.
- REQ: ce_n=0, insp held stable. On valid=1 → CAPT (or DROP if discard flag set); insp advances by 1 on that edge, modulo 2^ADDR_WIDTH.
- CAPT: ce_n=1. insr written to tail at end of cycle. Next: REQ if fetch_en and post-cycle count<DEPTH, else IDLE.
- DROP: ce_n=1, insr ignored, discard cleared, insp←redirect target → IDLE.
- At most one fetch in flight; a slot is reserved on REQ entry, so a push never overflows.
- Pop: dec_valid & dec_ready. Same-cycle push and pop: count unchanged.
- dec_valid = (count≠0) & ~flush (combinational gate; no transfer in flush cycle).
- Flush (priority over push and pop): count←0, head/tail pointers←0.
  - IDLE: insp←flush_pc next cycle.
  - REQ: BIU may already be mid-transaction; ce_n stays low, insp stays put, discard←1, redirect←flush_pc; that completion goes to DROP.
  - CAPT: word not written; insp←flush_pc; → IDLE.
  - DROP: redirect←flush_pc (latest flush wins).
- Pointers log2(DEPTH) bits wrapping naturally; count log2(DEPTH)+1 bits.

## Timing
- Reset values: insp=RESET_PC, ce_n=1, dec_valid=0, dec_data=0, dec_pc=0, count=0, state IDLE, discard=0.
- fetch_en high after reset: REQ in cycle 1, ce_n low from cycle 1.
- valid at edge E → word pushed at edge E+1 → dec_valid high in cycle after E+1.
- Back-to-back: CAPT→REQ direct, one ce_n-high cycle between fetches.
- Reset mid-fetch: immediate return to reset values; BIU shares rst.

## Configuration
- MXPFQ_PC_TAG_EN defined: each entry stores its fetch address; dec_pc port present, gives head address.
- Undefined: entries hold data only; dec_pc port and tag storage absent; all other behaviour identical.

## Structure
- mxpfq_pkg: state enum typedef (IDLE, REQ, CAPT, DROP), entry struct typedef (data, optional pc).
- Sub-module mxpfq_fifo: circular buffer with push, pop, clear, count, full/empty; top holds FSM, fetch PC, redirect register.

## Test plan
- Reset, fetch_en=1, BIU returns 0x11,0x22,0x33 at addresses 0,1,2 → decoder receives 0x11,0x22,0x33 with dec_pc 0,1,2.
- dec_ready=0, DEPTH=4 → exactly 4 fetches, ce_n stays high, insp=4; one pop → one more fetch at address 4.
- insp=0xFF, fetch completes → insp wraps to 0x00.
- Flush to 0x40 while in REQ with BIU mid-transaction → in-flight word dropped, queue empty, next ce_n low with insp=0x40, first dec_data from 0x40.
- Flush and dec_ready in same cycle, 2 entries queued → dec_valid=0 that cycle, count=0 afterwards.
- rst asserted while REQ → ce_n=1, insp=RESET_PC, dec_valid=0 immediately, without waiting for an edge.
